// File: rtl/counter_sequencer.sv
// Programmable period timer controlling an external free-running up-counter:
// prescaler, terminal-count compare, repeat count and start/stop/pause control.
module counter_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  PAUSE,
    input  logic [WIDTH-1:0]      TARGET,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [3:0]            REPEAT,
    input  logic [WIDTH-1:0]      CNT_VALUE,
    output logic                  CNT_EN,
    output logic                  CNT_CLR,
    output logic                  BUSY,
    output logic                  WRAP,
    output logic                  DONE,
    output logic [3:0]            RUN_COUNT
);

    localparam int unsigned RC_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] pre;
    logic [WIDTH-1:0]      tgt;
    logic [PRESCALE_W-1:0] ps;
    logic [RC_W-1:0]       rep;

    logic            tick;
    logic            period_end;
    logic            final_period;
    logic [RC_W-1:0] run_count_nxt;

    // Counter control is decoded from registered state plus the value feedback.
    always_comb begin
        tick          = (state == RUN) && (pre == ps);
        period_end    = tick && (CNT_VALUE == tgt);
        run_count_nxt = RUN_COUNT + RC_W'(1);
        final_period  = (rep != '0) && (run_count_nxt == rep);
    end

    assign CNT_EN  = tick && !period_end;
    assign CNT_CLR = (state == IDLE) || period_end;
    assign BUSY    = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            pre       <= '0;
            tgt       <= '0;
            ps        <= '0;
            rep       <= '0;
            RUN_COUNT <= '0;
            WRAP      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        tgt       <= TARGET;
                        ps        <= PRESCALE;
                        rep       <= REPEAT;
                        pre       <= '0;
                        RUN_COUNT <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    pre <= tick ? '0 : pre + PRESCALE_W'(1);
                    // A period end always counts and wraps, even when STOP wins.
                    if (period_end) begin
                        RUN_COUNT <= run_count_nxt;
                        WRAP      <= 1'b1;
                    end
                    if (STOP) begin
                        state <= IDLE;
                    end else if (period_end && final_period) begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                    end else if (PAUSE) begin
                        state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (STOP) begin
                        state <= IDLE;
                    end else if (!PAUSE) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer driving a real up-counter.
module tb_counter_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START, STOP, PAUSE;
    logic [7:0] TARGET;
    logic [3:0] PRESCALE;
    logic [3:0] REPEAT;
    logic [7:0] CNT_VALUE;
    logic       CNT_EN, CNT_CLR, BUSY, WRAP, DONE;
    logic [3:0] RUN_COUNT;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .PAUSE(PAUSE),
        .TARGET(TARGET), .PRESCALE(PRESCALE), .REPEAT(REPEAT),
        .CNT_VALUE(CNT_VALUE), .CNT_EN(CNT_EN), .CNT_CLR(CNT_CLR),
        .BUSY(BUSY), .WRAP(WRAP), .DONE(DONE), .RUN_COUNT(RUN_COUNT)
    );

    always #5 CLK = ~CLK;

    // The controlled counter datapath
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        CNT_VALUE <= '0;
        else if (CNT_CLR) CNT_VALUE <= '0;
        else if (CNT_EN)  CNT_VALUE <= CNT_VALUE + 8'd1;
    end

    task automatic start_run(input logic [7:0] t, input logic [3:0] p, input logic [3:0] r);
        TARGET = t; PRESCALE = p; REPEAT = r; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (CNT_EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", CNT_EN); end
        checks++; if (CNT_CLR !== 1'b1) begin errors++; $display("FAIL reset_clr: got %b expected 1", CNT_CLR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if ({WRAP, DONE} !== 2'b00) begin errors++; $display("FAIL reset_wrap_done: got %b expected 00", {WRAP, DONE}); end
        checks++; if (RUN_COUNT !== 4'd0) begin errors++; $display("FAIL reset_run_count: got %0d expected 0", RUN_COUNT); end
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (CNT_VALUE !== 8'd0 || CNT_CLR !== 1'b1) begin errors++; $display("FAIL idle_hold: got cnt=%0d clr=%b expected cnt=0 clr=1", CNT_VALUE, CNT_CLR); end
    endtask

    task automatic test_basic;
        logic [7:0] ec;
        start_run(8'd3, 4'd0, 4'd2);
        for (int i = 0; i < 8; i++) begin
            ec = 8'(i % 4);
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b expected 1", i, BUSY); end
            checks++; if (CNT_VALUE !== ec) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d expected %0d", i, CNT_VALUE, ec); end
            checks++; if (CNT_EN !== (ec != 8'd3)) begin errors++; $display("FAIL basic_en[%0d]: got %b expected %b", i, CNT_EN, ec != 8'd3); end
            checks++; if (CNT_CLR !== (ec == 8'd3)) begin errors++; $display("FAIL basic_clr[%0d]: got %b expected %b", i, CNT_CLR, ec == 8'd3); end
            checks++; if (WRAP !== (i == 4)) begin errors++; $display("FAIL basic_wrap[%0d]: got %b expected %b", i, WRAP, i == 4); end
            checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done[%0d]: got %b expected 0", i, DONE); end
            @(negedge CLK);
        end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_end_busy: got %b expected 0", BUSY); end
        checks++; if ({WRAP, DONE} !== 2'b11) begin errors++; $display("FAIL basic_end_wrap_done: got %b expected 11", {WRAP, DONE}); end
        checks++; if (RUN_COUNT !== 4'd2) begin errors++; $display("FAIL basic_run_count: got %0d expected 2", RUN_COUNT); end
        checks++; if (CNT_VALUE !== 8'd0 || CNT_CLR !== 1'b1) begin errors++; $display("FAIL basic_end_cnt: got cnt=%0d clr=%b expected cnt=0 clr=1", CNT_VALUE, CNT_CLR); end
        @(negedge CLK);
        checks++; if ({WRAP, DONE} !== 2'b00) begin errors++; $display("FAIL basic_pulse_width: got %b expected 00", {WRAP, DONE}); end
    endtask

    task automatic test_prescale;
        start_run(8'd1, 4'd2, 4'd1);
        for (int i = 0; i < 6; i++) begin
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL ps_busy[%0d]: got %b expected 1", i, BUSY); end
            checks++; if (CNT_VALUE !== 8'(i / 3)) begin errors++; $display("FAIL ps_cnt[%0d]: got %0d expected %0d", i, CNT_VALUE, i / 3); end
            checks++; if (CNT_EN !== (i == 2)) begin errors++; $display("FAIL ps_en[%0d]: got %b expected %b", i, CNT_EN, i == 2); end
            checks++; if (CNT_CLR !== (i == 5)) begin errors++; $display("FAIL ps_clr[%0d]: got %b expected %b", i, CNT_CLR, i == 5); end
            checks++; if ({WRAP, DONE} !== 2'b00) begin errors++; $display("FAIL ps_pulse[%0d]: got %b expected 00", i, {WRAP, DONE}); end
            @(negedge CLK);
        end
        checks++; if ({BUSY, WRAP, DONE} !== 3'b011) begin errors++; $display("FAIL ps_end: got busy/wrap/done=%b expected 011", {BUSY, WRAP, DONE}); end
        checks++; if (RUN_COUNT !== 4'd1) begin errors++; $display("FAIL ps_run_count: got %0d expected 1", RUN_COUNT); end
        @(negedge CLK);
    endtask

    task automatic test_pause;
        logic [7:0] exp_cnt [10];
        logic       exp_en  [10];
        exp_cnt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd5};
        exp_en  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        start_run(8'd5, 4'd0, 4'd1);
        for (int i = 0; i < 10; i++) begin
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL pause_busy[%0d]: got %b expected 1", i, BUSY); end
            checks++; if (CNT_VALUE !== exp_cnt[i]) begin errors++; $display("FAIL pause_cnt[%0d]: got %0d expected %0d", i, CNT_VALUE, exp_cnt[i]); end
            checks++; if (CNT_EN !== exp_en[i]) begin errors++; $display("FAIL pause_en[%0d]: got %b expected %b", i, CNT_EN, exp_en[i]); end
            checks++; if (CNT_CLR !== (i == 9)) begin errors++; $display("FAIL pause_clr[%0d]: got %b expected %b", i, CNT_CLR, i == 9); end
            checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL pause_done[%0d]: got %b expected 0", i, DONE); end
            PAUSE = (i >= 2 && i <= 5);
            @(negedge CLK);
        end
        checks++; if ({BUSY, WRAP, DONE} !== 3'b011) begin errors++; $display("FAIL pause_end: got busy/wrap/done=%b expected 011", {BUSY, WRAP, DONE}); end
        @(negedge CLK);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL pause_done_once: got %b expected 0", DONE); end
    endtask

    task automatic test_stop;
        start_run(8'd4, 4'd0, 4'd1);
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (CNT_VALUE !== 8'd2) begin errors++; $display("FAIL stop_pre_cnt: got %0d expected 2", CNT_VALUE); end
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        checks++; if ({BUSY, CNT_CLR, CNT_EN} !== 3'b010) begin errors++; $display("FAIL stop_idle: got busy/clr/en=%b expected 010", {BUSY, CNT_CLR, CNT_EN}); end
        checks++; if ({WRAP, DONE} !== 2'b00) begin errors++; $display("FAIL stop_no_pulse: got %b expected 00", {WRAP, DONE}); end
        @(negedge CLK);
        checks++; if ({WRAP, DONE, CNT_VALUE} !== {2'b00, 8'd0}) begin errors++; $display("FAIL stop_after: got wrap/done=%b cnt=%0d expected 00 cnt=0", {WRAP, DONE}, CNT_VALUE); end
        // START and STOP together in IDLE must not start
        START = 1'b1; STOP = 1'b1;
        @(negedge CLK);
        START = 1'b0; STOP = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL start_stop_idle: got busy=%b expected 0", BUSY); end
        // START while BUSY with a different TARGET is ignored
        start_run(8'd1, 4'd0, 4'd1);
        START = 1'b1; TARGET = 8'd5;
        @(negedge CLK);
        START = 1'b0;
        checks++; if ({CNT_VALUE, CNT_CLR} !== {8'd1, 1'b1}) begin errors++; $display("FAIL busy_start_tgt: got cnt=%0d clr=%b expected cnt=1 clr=1", CNT_VALUE, CNT_CLR); end
        @(negedge CLK);
        checks++; if ({BUSY, DONE} !== 2'b01) begin errors++; $display("FAIL busy_start_done: got busy/done=%b expected 01", {BUSY, DONE}); end
        @(negedge CLK);
    endtask

    task automatic test_continuous;
        start_run(8'd0, 4'd1, 4'd0);
        for (int i = 0; i <= 32; i++) begin
            checks++; if (CNT_CLR !== (i % 2 == 1)) begin errors++; $display("FAIL cont_clr[%0d]: got %b expected %b", i, CNT_CLR, i % 2 == 1); end
            checks++; if (WRAP !== (i >= 2 && i % 2 == 0)) begin errors++; $display("FAIL cont_wrap[%0d]: got %b expected %b", i, WRAP, i >= 2 && i % 2 == 0); end
            checks++; if (RUN_COUNT !== 4'((i / 2) % 16)) begin errors++; $display("FAIL cont_run_count[%0d]: got %0d expected %0d", i, RUN_COUNT, (i / 2) % 16); end
            checks++; if ({DONE, BUSY, CNT_VALUE} !== {2'b01, 8'd0}) begin errors++; $display("FAIL cont_state[%0d]: got done/busy=%b cnt=%0d expected 01 cnt=0", i, {DONE, BUSY}, CNT_VALUE); end
            if (i < 32) @(negedge CLK);
        end
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        checks++; if ({BUSY, WRAP, DONE} !== 3'b000) begin errors++; $display("FAIL cont_stop: got busy/wrap/done=%b expected 000", {BUSY, WRAP, DONE}); end
        @(negedge CLK);
    endtask

    task automatic test_reset_midrun;
        start_run(8'd1, 4'd0, 4'd0);
        repeat (5) @(negedge CLK);
        checks++; if (RUN_COUNT !== 4'd2) begin errors++; $display("FAIL midrun_pre_count: got %0d expected 2", RUN_COUNT); end
        #2 RESET = 1'b1;
        #1;
        checks++; if ({CNT_EN, CNT_CLR, BUSY} !== 3'b010) begin errors++; $display("FAIL midrun_reset: got en/clr/busy=%b expected 010", {CNT_EN, CNT_CLR, BUSY}); end
        checks++; if (RUN_COUNT !== 4'd0) begin errors++; $display("FAIL midrun_run_count: got %0d expected 0", RUN_COUNT); end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        start_run(8'd2, 4'd0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({BUSY, CNT_VALUE} !== {1'b1, 8'(i)}) begin errors++; $display("FAIL post_reset_cnt[%0d]: got busy=%b cnt=%0d expected busy=1 cnt=%0d", i, BUSY, CNT_VALUE, i); end
            @(negedge CLK);
        end
        checks++; if ({BUSY, WRAP, DONE} !== 3'b011) begin errors++; $display("FAIL post_reset_done: got busy/wrap/done=%b expected 011", {BUSY, WRAP, DONE}); end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0;
        TARGET = '0; PRESCALE = '0; REPEAT = '0;
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        test_basic();
        test_prescale();
        test_pause();
        test_stop();
        test_continuous();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller for the team's free-running up-counter datapath. It turns a plain counter into a programmable period timer.
- It drives the counter's synchronous clear and count-enable, using its current value as feedback.
- Adds a prescaler, a terminal-count compare, a repeat count, and start/stop/pause control.
- Sits between the host/control logic and one counter instance. It produces WRAP/DONE event pulses for downstream logic.

Parameters:
- WIDTH, 8, counter width; also the width of TARGET and CNT_VALUE.
- PRESCALE_W, 4, width of the PRESCALE field.

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset, asynchronous, active-high.
- START  input  1  start request; sampled only in IDLE.
- STOP  input  1  abort request; returns the block to IDLE.
- PAUSE  input  1  level; freezes counting while high.
- TARGET  input  WIDTH  terminal count value; latched at START.
- PRESCALE  input  PRESCALE_W  clocks per count = PRESCALE+1; latched at START.
- REPEAT  input  4  number of periods to run; 0 = run forever; latched at START.
- CNT_VALUE  input  WIDTH  current value of the controlled counter.
- CNT_EN  output  1  count-enable to the counter.
- CNT_CLR  output  1  synchronous clear to the counter; has priority over CNT_EN in the counter.
- BUSY  output  1  high when state is not IDLE.
- WRAP  output  1  one-cycle pulse after every period end.
- DONE  output  1  one-cycle pulse after the final period of a finite run.
- RUN_COUNT  output  4  completed periods since START; wraps modulo 16.

Behaviour:
- Counter contract: the counter updates on the next CLK edge; CLR clears to 0; EN adds 1.
- States are IDLE, RUN and PAUSED. State, prescaler (pre), shadow config (tgt, ps, rep) and RUN_COUNT are registers.
- Reset (async, any time, including mid-run): state=IDLE, pre=0, RUN_COUNT=0, WRAP=0, DONE=0.
  - Output values under reset: CNT_EN=0, CNT_CLR=1, BUSY=0.
- CNT_CLR and CNT_EN are decoded from registered state plus the CNT_VALUE compare. No other input-to-output combinational path exists.
- Let tick = (state==RUN) && (pre==ps), and end = tick && (CNT_VALUE==tgt).
  - CNT_EN = tick && !end.
  - CNT_CLR = (state==IDLE) || end.
  - In IDLE the counter is therefore held at 0.
- IDLE:
  - START=1 and STOP=0: latch TARGET/PRESCALE/REPEAT, pre=0, RUN_COUNT=0, go to RUN.
  - START and STOP in the same cycle: stay IDLE.
- RUN:
  - pre increments each cycle and resets to 0 on tick.
  - Each counter value is held ps+1 cycles. Period = (tgt+1)*(ps+1) cycles.
  - On end: RUN_COUNT increments; WRAP=1 in the next cycle.
  - If rep!=0 and RUN_COUNT+1==rep: go to IDLE, and DONE=1 in the next cycle (coincident with the final WRAP).
  - Otherwise stay in RUN; the counter restarts from 0.
- PAUSE is sampled at the clock edge.
  - RUN with PAUSE=1 → PAUSED. Any tick/end in that same cycle still takes effect.
  - PAUSED: pre, the counter and RUN_COUNT are frozen; CNT_EN=0, CNT_CLR=0.
  - PAUSED with PAUSE=0 → RUN, resuming with the same pre value.
- STOP=1 in RUN or PAUSED → IDLE next cycle.
  - STOP beats PAUSE and beats a final-period completion in the same cycle: no DONE is issued.
  - A WRAP for an end occurring in that same cycle is still issued.
- START while BUSY is ignored. Changes to TARGET/PRESCALE/REPEAT while BUSY are ignored.
- tgt=0 is legal: the counter stays at 0, with CNT_CLR once per ps+1 cycles.
- RUN_COUNT wraps 15→0 when rep=0. It holds its value in IDLE until the next START.
- WRAP and DONE are registered and never last longer than one cycle.

Test Plan:
- Basic run: TARGET=3, PRESCALE=0, REPEAT=2, START pulse.
  - Required: BUSY for 8 cycles; CNT_VALUE sequence 0,1,2,3,0,1,2,3.
  - CNT_EN high 3 of every 4 cycles and CNT_CLR on each value 3.
  - WRAP pulses 4 cycles apart; DONE coincident with the 2nd WRAP; RUN_COUNT=2; counter ends at 0 with CNT_CLR held.
- Prescale: TARGET=1, PRESCALE=2, REPEAT=1.
  - Required: CNT_EN high one cycle in 3; value 1 held 3 cycles; period 6 cycles; single WRAP+DONE; BUSY drops after 6 cycles.
- Pause: TARGET=5, PRESCALE=0, REPEAT=1, with PAUSE high for 4 cycles when CNT_VALUE=2.
  - Required: value frozen at 2 (or 3 if a tick coincided); CNT_EN=0 throughout; total BUSY = 6+4 cycles; DONE once.
- Stop/priority: STOP asserted at CNT_VALUE=2 of TARGET=4, REPEAT=1.
  - Required: IDLE next cycle, CNT_CLR=1, no DONE, no WRAP.
  - Also: START+STOP together in IDLE → BUSY stays 0.
  - Also: START while BUSY with a new TARGET → ignored; the old TARGET continues to be used.
- Continuous run: TARGET=0, PRESCALE=1, REPEAT=0.
  - Required: CNT_CLR every 2nd cycle and WRAP every 2 cycles.
  - RUN_COUNT goes 15→0 after the 16th period; DONE never asserts; STOP ends the run.
- Reset mid-run: RESET asserted asynchronously between edges during RUN.
  - Required: CNT_EN=0, CNT_CLR=1, BUSY=0, RUN_COUNT=0 immediately.
  - After release, START works normally.
